regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/regfile_wb_arbiter.sv | 92 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the register-file writeback path: register geometry
// and the fixed requester index assignment.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 128;
    localparam int NUM_REGS   = 32;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_AI  = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: the requester at ptr has top priority,
// then the search wraps upward modulo N. gnt is one-hot, or zero with no req.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic found;
    int   idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates register-file writebacks between the ALU, LSU and AI unit and
// tracks pending destination registers in a busy scoreboard.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = REG_DATA_W,
    parameter int ADDR_W  = REG_ADDR_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        wb_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] wb_addr,
    input  logic [NUM_REQ*DATA_W-1:0] wb_data,
    output logic [NUM_REQ-1:0]        wb_ready,
    input  logic                      issue_valid,
    input  logic [ADDR_W-1:0]         issue_rd,
    input  logic [ADDR_W-1:0]         query_rs1,
    input  logic [ADDR_W-1:0]         query_rs2,
    output logic                      busy_rs1,
    output logic                      busy_rs2,
    output logic                      rf_reg_write,
    output logic [ADDR_W-1:0]         rf_write_reg,
    output logic [DATA_W-1:0]         rf_write_data
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NREGS = 2 ** ADDR_W;

    // Handshake: requester i transfers at a rising edge where wb_valid[i] and
    // wb_ready[i] are both high; ready depends only on valid and the pointer.
    logic [PTR_W-1:0]  ptr;
    logic [NUM_REQ-1:0] gnt;
    logic [PTR_W-1:0]  gnt_idx;
    logic              xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req (wb_valid),
        .ptr (ptr),
        .gnt (gnt)
    );

    assign wb_ready = gnt;
    assign xfer     = |gnt;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) gnt_idx = PTR_W'(i);
        end
    end

    assign sel_addr = wb_addr[gnt_idx*ADDR_W +: ADDR_W];
    assign sel_data = wb_data[gnt_idx*DATA_W +: DATA_W];

    // Set is applied after clear so a freshly issued producer stays pending.
    always_comb begin
        busy_d = busy_q;
        if (xfer && (sel_addr != '0)) busy_d[sel_addr] = 1'b0;
        if (issue_valid && (issue_rd != '0)) busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr           <= '0;
            busy_q        <= '0;
            rf_reg_write  <= 1'b0;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
        end else begin
            busy_q       <= busy_d;
            rf_reg_write <= xfer && (sel_addr != '0);
            if (xfer) begin
                ptr           <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
                rf_write_reg  <= sel_addr;
                rf_write_data <= sel_data;
            end
        end
    end

    assign busy_rs1 = busy_q[query_rs1];
    assign busy_rs2 = busy_q[query_rs2];

endmodule
